// File: rtl/booth_r4_control.sv
// -----------------------------------------------------------------------------
// booth_r4_control
//
// Sequencer for the radix-4 Booth multiplier datapath. It runs one
// multiplication for each accepted start request. The datapath contains the
// accumulator A, the multiplicand M and 2M, the multiplier Q, the q_1 flop and
// the adder/subtractor. Each OPER step decodes the Booth digit from
// {q1, q0, q_1}, and each SHIFT step moves A:Q right by two bits.
//
// Parameters
//   ITER       number of radix-4 iterations (operand width / 2)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active high
//   start      begins a multiplication; only looked at in IDLE
//   q1, q0     Q[1], Q[0] from the datapath
//   q_1        previous Q[1] from the datapath
//   reset_dp   clears every datapath register (also follows reset)
//   carga_qm   loads Q and M/2M from the operand inputs
//   carga_a    loads A with the adder/subtractor result
//   mux_selec  adder operand select: 1 = 2M, 0 = M
//   resta      1 = A - operand, 0 = A + operand
//   desplaza   2-bit arithmetic right shift of A:Q, with Q[1] moved into q_1
//   ocupado    high whenever the sequencer is not in IDLE
//   fin        one-cycle pulse; the product is valid on the datapath result
// -----------------------------------------------------------------------------
module booth_r4_control #(
  parameter int ITER = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q1,
  input  logic q0,
  input  logic q_1,
  output logic reset_dp,
  output logic carga_qm,
  output logic carga_a,
  output logic mux_selec,
  output logic resta,
  output logic desplaza,
  output logic ocupado,
  output logic fin
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    OPER  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          clr_strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The datapath clear also follows the controller reset. The datapath is
  // then known to be clean even if it shares no reset with this block.
  assign reset_dp = reset | clr_strobe;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_strobe = 1'b0;
    carga_qm   = 1'b0;
    carga_a    = 1'b0;
    mux_selec  = 1'b0;
    resta      = 1'b0;
    desplaza   = 1'b0;
    ocupado    = 1'b0;
    fin        = 1'b0;

    // While reset is held, the registered state may still hold an old value.
    // Gate all strobes so that the datapath sees only reset_dp during that cycle.
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (start) state_next = CLR;
        end

        CLR: begin
          ocupado    = 1'b1;
          clr_strobe = 1'b1;
          cnt_next   = '0;
          state_next = LOAD;
        end

        LOAD: begin
          ocupado    = 1'b1;
          carga_qm   = 1'b1;
          state_next = OPER;
        end

        OPER: begin
          ocupado    = 1'b1;
          state_next = SHIFT;
          // Booth digit d = -2*q1 + q0 + q_1, with d in {-2..+2}.
          // carga_a marks d != 0, mux_selec marks |d| = 2 and resta marks d < 0.
          case ({q1, q0, q_1})
            3'b001, 3'b010: begin
              carga_a = 1'b1;
            end
            3'b011: begin
              carga_a   = 1'b1;
              mux_selec = 1'b1;
            end
            3'b100: begin
              carga_a   = 1'b1;
              mux_selec = 1'b1;
              resta     = 1'b1;
            end
            3'b101, 3'b110: begin
              carga_a = 1'b1;
              resta   = 1'b1;
            end
            default: begin
              // d = 0: A is left unchanged.
            end
          endcase
        end

        SHIFT: begin
          ocupado  = 1'b1;
          desplaza = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt_reg + CNT_ONE;
            state_next = OPER;
          end
        end

        DONE: begin
          // The datapath is not touched here, so the result holds until the
          // next CLR.
          ocupado    = 1'b1;
          fin        = 1'b1;
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_control.sv
// -----------------------------------------------------------------------------
// tb_booth_r4_control
//
// Closed-loop bench. A behavioural 4x4 Booth datapath (A, M, Q, q_1) is
// driven by the controller strobes and returns the Booth triplet to the
// controller. The expected values come from three sources:
//   * the per-cycle strobe timeline after start (CLR, LOAD, OPER, SHIFT, ...)
//   * the OPER strobes, taken from the signed Booth digit -2*q1 + q0 + q_1
//   * the product, from plain signed multiplication of the operands
// -----------------------------------------------------------------------------
module tb_booth_r4_control;

  logic clk = 1'b0;
  logic reset, start;
  logic q1, q0, q_1;
  logic reset_dp, carga_qm, carga_a, mux_selec, resta, desplaza, ocupado, fin;

  int tests_run  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  booth_r4_control #(.ITER(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q1        (q1),
    .q0        (q0),
    .q_1       (q_1),
    .reset_dp  (reset_dp),
    .carga_qm  (carga_qm),
    .carga_a   (carga_a),
    .mux_selec (mux_selec),
    .resta     (resta),
    .desplaza  (desplaza),
    .ocupado   (ocupado),
    .fin       (fin)
  );

  // ---------------- behavioural datapath ----------------
  logic signed [3:0] m_in, q_in;
  logic [5:0] a_r, m_r;
  logic [3:0] q_r;
  logic       qm1_r;
  logic [5:0] opnd;
  logic [9:0] shifted;
  logic [7:0] result;

  assign opnd    = mux_selec ? {m_r[4:0], 1'b0} : m_r;
  assign shifted = 10'($signed({a_r, q_r}) >>> 2);
  assign result  = {a_r[3:0], q_r};
  assign q1      = q_r[1];
  assign q0      = q_r[0];
  assign q_1     = qm1_r;

  always @(posedge clk) begin
    if (reset_dp) begin
      a_r <= '0; m_r <= '0; q_r <= '0; qm1_r <= 1'b0;
    end else if (carga_qm) begin
      q_r   <= q_in;
      m_r   <= {{2{m_in[3]}}, m_in};
      qm1_r <= 1'b0;
    end else if (carga_a) begin
      a_r <= resta ? (a_r - opnd) : (a_r + opnd);
    end else if (desplaza) begin
      a_r   <= shifted[9:4];
      q_r   <= shifted[3:0];
      qm1_r <= q_r[1];
    end
  end

  // Output bits: reset_dp carga_qm carga_a mux_selec resta desplaza ocupado fin
  logic [7:0] obs;
  assign obs = {reset_dp, carga_qm, carga_a, mux_selec, resta, desplaza, ocupado, fin};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected output vector for cycle c after the edge that sampled start.
  function automatic logic [7:0] expected_vec(input int c, input logic b1,
                                              input logic b0, input logic bm1);
    int d;
    logic [7:0] v;
    d = -2 * int'(b1) + int'(b0) + int'(bm1);
    case (c)
      1:       v = 8'b1000_0010;
      2:       v = 8'b0100_0010;
      3, 5:    v = {2'b00, d != 0, (d == 2 || d == -2), d < 0, 3'b010};
      4, 6:    v = 8'b0000_0110;
      7:       v = 8'b0000_0011;
      default: v = 8'b0000_0000;
    endcase
    return v;
  endfunction

  // One multiplication. pulse_c: cycle at which start is raised for one
  // cycle while the operation is busy (0 = none). abort_c: cycle after which
  // reset is raised for one cycle (0 = none).
  task automatic run_mul(input logic signed [3:0] a, input logic signed [3:0] b,
                         input int pulse_c, input int abort_c, input string tag);
    logic [7:0] exp_v;
    logic [7:0] prod;
    int fins, adds, shifts, fin_c;
    fins = 0; adds = 0; shifts = 0; fin_c = 0;
    prod = 8'(int'(a) * int'(b));
    @(negedge clk);
    m_in = a; q_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == pulse_c);
      exp_v = expected_vec(c, q1, q0, q_1);
      if (abort_c != 0 && c > abort_c)
        exp_v = (c == abort_c + 1) ? 8'h80 : 8'h00;
      check({tag, "_vec"}, 32'(obs), 32'(exp_v));
      if (fin) begin fins++; fin_c = c; end
      if (carga_a)  adds++;
      if (desplaza) shifts++;
      if (abort_c == 0 && c == 7) check({tag, "_result"}, 32'(result), 32'(prod));
      if (abort_c != 0 && c == abort_c) reset = 1'b1;
      if (abort_c != 0 && c == abort_c + 1) reset = 1'b0;
    end
    start = 1'b0;
    check({tag, "_fin_count"}, 32'(fins), (abort_c == 0) ? 32'd1 : 32'd0);
    if (abort_c == 0) check({tag, "_latency"}, 32'(fin_c), 32'd7);
    if (b == 4'sd0) begin
      check({tag, "_adds"}, 32'(adds), 32'd0);
      check({tag, "_shifts"}, 32'(shifts), 32'd2);
    end
    $display("[TB] %s: %0d x %0d -> result=%h expected=%h fins=%0d adds=%0d shifts=%0d",
             tag, a, b, result, prod, fins, adds, shifts);
  endtask

  initial begin
    int fin_times[$];
    logic signed [3:0] ra, rb;
    int pc;

    reset = 1'b1; start = 1'b1; m_in = '0; q_in = '0;

    // Reset held two cycles with start high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_vec", 32'(obs), 32'h80);
    end
    reset = 1'b0;
    @(negedge clk);
    check("first_clr", 32'(obs), 32'h82);
    start = 1'b0;
    for (int i = 0; i < 12 && ocupado; i++) @(negedge clk);
    check("reset_drain_idle", 32'(ocupado), 32'd0);
    $display("[TB] reset sequence done");

    // Directed products.
    run_mul(4'sd7,  4'sd7,  0, 0, "m7x7");
    run_mul(4'sd3, -4'sd2,  0, 0, "m3xn2");
    run_mul(-4'sd8, 4'sd7,  0, 0, "mn8x7");
    run_mul(-4'sd8, -4'sd8, 0, 0, "mn8xn8");
    run_mul(4'sd5,  4'sd0,  0, 0, "m5x0");
    run_mul(4'sd6,  4'sd5,  4, 0, "start_in_shift");
    run_mul(4'sd7,  4'sd7,  0, 5, "abort_oper2");
    run_mul(-4'sd3, 4'sd6,  0, 0, "after_abort");

    // start held high: one fin every 8 cycles.
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fin) fin_times.push_back(c);
    end
    start = 1'b0;
    check("hold_fin_count", 32'(fin_times.size()), 32'd5);
    for (int i = 1; i < fin_times.size(); i++)
      check("hold_period", 32'(fin_times[i] - fin_times[i-1]), 32'd8);
    for (int i = 0; i < 12 && ocupado; i++) @(negedge clk);
    check("hold_drain_idle", 32'(ocupado), 32'd0);
    $display("[TB] start held: %0d fin pulses", fin_times.size());

    // Random operands, with an occasional start pulse while busy.
    for (int n = 0; n < 24; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      pc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      run_mul(ra, rb, pc, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_r4_control.md
# booth_r4_control

Control unit for the 4×4 radix-4 Booth multiplier. It sits directly upstream of the Booth datapath (accumulator A, multiplicand M/2M, multiplier Q, q_1 flip-flop, adder/subtractor) and drives all of its load, shift, select and add/subtract strobes. It sequences one multiplication per `start` request, deciding each step from the datapath's `q1`, `q0` and `q_1` bits, and reports `fin` when the 8-bit product is valid.

## Interface
- `ITER`, default 2: number of radix-4 iterations (operand width / 2).
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `start`  in  1: request a multiplication; sampled only in IDLE.
- `q1`, `q0`, `q_1`  in  1 each: Booth triplet from the datapath (Q[1], Q[0], previous Q[1]).
- `reset_dp`  out  1: synchronous clear of every datapath register (A, M, 2M, Q, q_1).
- `carga_qm`  out  1: load Q and M/2M from the operand inputs.
- `carga_a`  out  1: load A with the adder/subtractor output.
- `mux_selec`  out  1: 1 selects 2M, 0 selects M as the adder operand.
- `resta`  out  1: 1 computes A − operand, 0 computes A + operand.
- `desplaza`  out  1: 2-bit arithmetic right shift of A:Q, with Q[1] captured into q_1.
- `ocupado`  out  1: high in every state except IDLE.
- `fin`  out  1: one-cycle pulse; product valid on datapath `result`.

## Operation
- States: IDLE, CLR, LOAD, OPER, SHIFT, DONE. Iteration counter `cnt`, width clog2(ITER), minimum 1 bit.
- IDLE: all strobes 0. If `start`=1, go to CLR.
- CLR: `reset_dp`=1, `cnt`←0. Go to LOAD.
- LOAD: `carga_qm`=1. Go to OPER.
- OPER: strobes are decoded combinationally from {q1,q0,q_1}.
  - 000, 111: `carga_a`=0.
  - 001, 010: `carga_a`=1, `mux_selec`=0, `resta`=0 (+M).
  - 011: `carga_a`=1, `mux_selec`=1, `resta`=0 (+2M).
  - 100: `carga_a`=1, `mux_selec`=1, `resta`=1 (−2M).
  - 101, 110: `carga_a`=1, `mux_selec`=0, `resta`=1 (−M).
  - Always go to SHIFT next.
- SHIFT: `desplaza`=1.
  - If `cnt`=ITER−1, go to DONE.
  - Otherwise `cnt`←`cnt`+1 and go to OPER.
- DONE: `fin`=1. Go to IDLE. Datapath registers are left untouched, so `result` holds until the next CLR.
- `mux_selec` and `resta` are 0 whenever `carga_a`=0.
- No state asserts more than one of {`carga_qm`, `carga_a`, `desplaza`}.
- `reset_dp` = `reset` OR (state = CLR).
- `start` is ignored in every state other than IDLE. A `start` held high through DONE begins a new operation on the cycle after DONE.
- Unused state encodings go to IDLE on the next edge.

## Timing
- Reset: state IDLE, `cnt`=0. `reset_dp`=1 while `reset` is high. All other outputs are 0.
- `reset` mid-operation: IDLE on the next edge, with no `fin`.
- With `start` sampled at edge k, states by cycle after each edge are:
  - k: CLR
  - k+1: LOAD
  - k+2: OPER
  - k+3: SHIFT
  - k+4: OPER
  - k+5: SHIFT
  - k+6: DONE
- `fin` is high for exactly the one cycle after edge k+6. Total latency is 7 cycles (general case: 3 + 2·ITER).
- OPER decode reads the triplet as it stands after the previous edge: Q after LOAD or after the previous shift. All strobes are valid before the next rising edge.
- Back-to-back throughput: one product every 8 cycles (IDLE revisited once).

## Test plan
- Reset: hold `reset` 2 cycles with `start`=1 -> `reset_dp`=1 throughout, all other outputs 0, state IDLE. The first CLR appears one edge after `reset` falls.
- Q=0111, M=0111 with the real datapath:
  - first OPER (triplet 110): `carga_a`=1, `resta`=1, `mux_selec`=0.
  - second OPER (triplet 011): `carga_a`=1, `mux_selec`=1, `resta`=0.
  - `fin` 7 cycles after `start`, `result`=8'h31 (49).
- Products with the real datapath, each with `fin` at cycle 7:
  - 3 × −2 -> `result`=8'hFA.
  - −8 × 7 -> `result`=8'hC8.
  - −8 × −8 -> `result`=8'h40.
- Q=0000, M=0101 -> `carga_a` never asserted, `desplaza` pulses exactly twice, `result`=8'h00.
- `start` pulsed during SHIFT of a running operation -> ignored, exactly one `fin`. `start` held high continuously -> `fin` every 8 cycles.
- `reset` asserted in the second OPER -> IDLE next edge, no `fin`. A new `start` then completes normally with the correct product.
